// File: rtl/pipe_cla_adder.sv
// Pipelined adder/subtractor: one SEG_W-bit carry-lookahead segment per stage.
// Define PIPE_CLA_SUB_EN to enable subtraction via i_sub.
module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int NGRP = SEG_W / 4;

    function automatic logic [4:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       co;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {co, p ^ c};
    endfunction

    // Lookahead inside each 4-bit group, group carries ripple across the segment.
    function automatic logic [SEG_W:0] seg_add(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             ci
    );
        logic [SEG_W-1:0] s;
        logic [4:0]       r;
        logic             c;
        s = '0;
        c = ci;
        for (int i = 0; i < NGRP; i++) begin
            r          = cla4(a[i*4 +: 4], b[i*4 +: 4], c);
            s[i*4 +: 4] = r[3:0];
            c          = r[4];
        end
        return {c, s};
    endfunction

    logic             en;
    logic             cin;
    logic [WIDTH-1:0] b_in;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;

`ifdef PIPE_CLA_SUB_EN
    assign cin  = i_sub;
    assign b_in = i_b ^ {WIDTH{i_sub}};
`else
    logic unused_sub;
    assign unused_sub = i_sub;
    assign cin        = 1'b0;
    assign b_in       = i_b;
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int RW = WIDTH - k * SEG_W;

        logic                     v_d;
        logic                     c_d;
        logic [RW-1:0]            a_d;
        logic [RW-1:0]            b_d;
        logic [(k+1)*SEG_W-1:0]   s_nx;
        logic [SEG_W:0]           seg;
        logic                     v_q;
        logic                     c_q;
        logic [(k+1)*SEG_W-1:0]   s_q;

        if (k == 0) begin : g_first
            assign v_d  = i_valid;
            assign c_d  = cin;
            assign a_d  = i_a;
            assign b_d  = b_in;
            assign s_nx = seg[SEG_W-1:0];
        end else begin : g_next
            assign v_d  = g_stage[k-1].v_q;
            assign c_d  = g_stage[k-1].c_q;
            assign a_d  = g_stage[k-1].g_fwd.a_q;
            assign b_d  = g_stage[k-1].g_fwd.b_q;
            assign s_nx = {seg[SEG_W-1:0], g_stage[k-1].s_q};
        end

        assign seg = seg_add(a_d[SEG_W-1:0], b_d[SEG_W-1:0], c_d);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= seg[SEG_W];
                s_q <= s_nx;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            // Skewed upper operand bits still waiting for their stage.
            logic [RW-SEG_W-1:0] a_q;
            logic [RW-SEG_W-1:0] b_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d[RW-1:SEG_W];
                    b_q <= b_d[RW-1:SEG_W];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic ovf_nx;

            // Carry into the MSB is recovered from its sum bit.
            assign ovf_nx = a_d[SEG_W-1] ^ b_d[SEG_W-1]
                          ^ seg[SEG_W-1] ^ seg[SEG_W];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_nx;
                end
            end

            assign o_valid = v_q;
            assign o_sum   = s_q;
            assign o_cout  = c_q;
            assign o_ovf   = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed bench for pipe_cla_adder: vector table plus backpressure,
// reset and single-stage sequences.
module tb_pipe_cla_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

`ifdef PIPE_CLA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_cout;
    logic        o_ovf;

    logic        v16;
    logic        r16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        ov16;
    logic [15:0] s16;
    logic        c16;
    logic        f16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(32), .SEG_W(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    pipe_cla_adder #(.WIDTH(16), .SEG_W(16)) u_dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v16),
        .o_ready (r16),
        .i_a     (a16),
        .i_b     (b16),
        .i_sub   (1'b0),
        .o_valid (ov16),
        .i_ready (1'b1),
        .o_sum   (s16),
        .o_cout  (c16),
        .o_ovf   (f16)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    vec_t tbl [9];

    initial begin
        int          lat;
        int          sent;
        int          rcvd;
        int          stall;
        int          cyc;
        bit          seen;
        logic [31:0] held;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = SUB_EN
               ? '{32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}
               : '{32'h5, 32'h7, 1'b1, 32'h0000_000C, 1'b0, 1'b0};
        tbl[3] = '{32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
        tbl[7] = SUB_EN
               ? '{32'hA, 32'h3, 1'b1, 32'h0000_0007, 1'b1, 1'b0}
               : '{32'hA, 32'h3, 1'b1, 32'h0000_000D, 1'b0, 1'b0};
        tbl[8] = SUB_EN
               ? '{32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}
               : '{32'h8000_0000, 32'h1, 1'b1, 32'h8000_0001, 1'b0, 1'b0};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        i_ready = 1'b1;
        v16     = 1'b0;
        a16     = '0;
        b16     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_sum", o_sum, 32'd0);
        chk("rst_cout_ovf", {30'd0, o_cout, o_ovf}, 32'd0);
        chk("rst_v16", {31'd0, ov16}, 32'd0);
        chk("rst_r16", {31'd0, r16}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            i_valid = 1'b1;
            i_a     = tbl[i].a;
            i_b     = tbl[i].b;
            i_sub   = tbl[i].sub;
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            lat     = 1;
            while (!o_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
            chk($sformatf("vec%0d_sum", i), o_sum, tbl[i].sum);
            chk($sformatf("vec%0d_cout", i), {31'd0, o_cout},
                {31'd0, tbl[i].cout});
            chk($sformatf("vec%0d_ovf", i), {31'd0, o_ovf},
                {31'd0, tbl[i].ovf});
        end
        i_sub = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", {31'd0, o_valid}, 32'd0);

        sent  = 0;
        rcvd  = 0;
        stall = 0;
        cyc   = 0;
        seen  = 1'b0;
        held  = '0;
        while (rcvd < 8 && cyc < 60) begin
            if (o_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
                held  = o_sum;
            end
            i_ready = (stall == 0);
            i_valid = (sent < 8);
            i_a     = sent + 1;
            i_b     = 32'h100 * (sent + 1);
            #1;
            chk("t4_ready", {31'd0, o_ready}, {31'd0, stall == 0});
            if (stall > 0) begin
                chk("t4_hold_sum", o_sum, held);
                chk("t4_hold_valid", {31'd0, o_valid}, 32'd1);
            end
            if (i_valid && o_ready) sent++;
            if (o_valid && i_ready) begin
                chk($sformatf("t4_sum%0d", rcvd), o_sum, 32'h101 * (rcvd + 1));
                rcvd++;
            end
            if (stall > 0) stall--;
            @(posedge clk);
            #1;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("t4_count", rcvd, 32'd8);
        chk("t4_stalled", {31'd0, seen}, 32'd1);

        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            i_valid = 1'b1;
            i_a     = j + 1;
            i_b     = 32'h0;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("t5_pre_valid", {31'd0, o_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, o_valid}, 32'd0);
        chk("t5_async_sum", o_sum, 32'd0);
        chk("t5_async_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t5_in_reset_ready", {31'd0, o_ready}, 32'd1);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t5_no_stale%0d", j), {31'd0, o_valid}, 32'd0);
        end

        v16 = 1'b1;
        a16 = 16'h8000;
        b16 = 16'h8000;
        @(posedge clk);
        #1;
        v16 = 1'b0;
        chk("t6_valid", {31'd0, ov16}, 32'd1);
        chk("t6_sum", {16'd0, s16}, 32'd0);
        chk("t6_cout", {31'd0, c16}, 32'd1);
        chk("t6_ovf", {31'd0, f16}, 32'd1);
        @(posedge clk);
        #1;
        chk("t6_bubble", {31'd0, ov16}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SEG_W, default 8, segment width per pipeline stage; WIDTH SHALL be a multiple of SEG_W, and SEG_W a multiple of 4.
REQ-003 SHALL define NSEG = WIDTH/SEG_W as the stage count and the latency.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all registers update on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, operand pair present.
REQ-007 SHALL have port o_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have ports i_a and i_b, input, WIDTH each, operands.
REQ-009 SHALL have port i_sub, input, 1, 1 = subtract (i_a - i_b), 0 = add.
REQ-010 SHALL have port o_valid, output, 1, result present.
REQ-011 SHALL have port i_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port o_sum, output, WIDTH, result.
REQ-013 SHALL have port o_cout, output, 1, carry out of the MSB (for subtract, 1 = no borrow).
REQ-014 SHALL have port o_ovf, output, 1, two's-complement signed overflow.

Function
REQ-015 Stage k (0..NSEG-1) SHALL compute bits [k*SEG_W +: SEG_W] with 4-bit carry-lookahead groups inside the segment; the carry SHALL be registered between stages.
REQ-016 Upper operand segments SHALL be skew-delayed and completed lower result segments deskew-delayed, so all WIDTH bits of one transaction leave together.
REQ-017 Stage 0 carry-in SHALL be i_sub, with b-input = i_b XOR {WIDTH{i_sub}}; i_sub SHALL travel with its transaction.
REQ-018 o_ovf SHALL be carry-into-MSB XOR carry-out-of-MSB of the same transaction.
REQ-019 A transfer in SHALL occur when i_valid && o_ready; a transfer out SHALL occur when o_valid && i_ready.
REQ-020 Global enable en = !o_valid || i_ready; o_ready SHALL equal en combinationally.
REQ-021 When en = 0, all stage data, carry and valid registers SHALL hold; o_sum, o_cout and o_ovf SHALL stay stable while o_valid && !i_ready.
REQ-022 Each stage SHALL carry a valid bit; an idle input cycle with en = 1 SHALL insert a bubble, and bubbles SHALL NOT raise o_valid.
REQ-023 Latency SHALL be exactly NSEG enabled cycles from input transfer to o_valid; throughput SHALL be one result per cycle while i_ready = 1.
REQ-024 Results SHALL emerge in acceptance order, with no loss or duplication under any i_ready pattern.
REQ-025 NSEG = 1 SHALL be legal: single-stage registered adder, latency 1.
REQ-026 Wrap-around SHALL be modulo 2^WIDTH; overflow SHALL be reported only via o_cout and o_ovf.

Reset
REQ-027 i_rst_n low SHALL immediately clear all valid bits, o_valid, o_sum, o_cout, o_ovf and internal data and carry registers to 0.
REQ-028 In-flight transactions at reset SHALL be discarded; no stale result SHALL appear after release.
REQ-029 o_ready SHALL be 1 during and after reset, since o_valid = 0.

Configuration
REQ-030 Macro PIPE_CLA_SUB_EN defined SHALL enable subtract per REQ-017.
REQ-031 Macro PIPE_CLA_SUB_EN undefined SHALL cause i_sub to be ignored, treated as 0, with no inverter or sub pipeline registers; the port SHALL remain present.

Verification (WIDTH=32, SEG_W=8 unless noted)
REQ-032 Test 1: a=0xFFFFFFFF, b=0x00000001, sub=0, i_ready=1. Required: after 4 cycles o_sum=0x00000000, o_cout=1, o_ovf=0.
REQ-033 Test 2: a=0x7FFFFFFF, b=0x00000001, sub=0. Required: o_sum=0x80000000, o_cout=0, o_ovf=1.
REQ-034 Test 3: a=5, b=7, sub=1. Required with PIPE_CLA_SUB_EN: o_sum=0xFFFFFFFE, o_cout=0, o_ovf=0. Required without it: o_sum=0x0000000C.
REQ-035 Test 4: 8 back-to-back transactions (a=i, b=0x100*i); i_ready low for 3 cycles at the first o_valid. Required: o_ready low in those cycles, output held, all 8 results correct and in order.
REQ-036 Test 5: i_rst_n low for one cycle with 3 transactions in flight. Required: o_valid=0 asynchronously, no result appears within 6 cycles after release without new input.
REQ-037 Test 6: WIDTH=16, SEG_W=16, a=0x8000, b=0x8000. Required: after 1 cycle o_sum=0x0000, o_cout=1, o_ovf=1.
